gf180mcu_fd_sc_mcu7t5v0__tie_release_seq: RTL and testbench
===========================================================

// Module: gf180mcu_fd_sc_mcu7t5v0__tie_release_seq
// PURPOSE
//  Staged tie-off release sequencer: the consumer end of the tie/well-tap network. Holds NGRP
//  logic groups tied to safe values after RN, then releases them one group at a time, waiting
//  for each group's ready/ack before the next. Forces every group back to tied on timeout or on
//  EN drop. Sits beside the tie/filltie rows; feeds block-level isolation and tie enables.
// PARAMETERS
//  NGRP      4   number of tie groups released in order 0..NGRP-1 (1..16)
//  STAGE_CYC 8   settle cycles counted before each group release (>=1)
//  TMO_CYC   16  max cycles waiting for ACK[g] after release (>=1)
// PORTS
//  CLK    in   1          rising-edge clock
//  RN     in   1          reset, synchronous, active-low
//  EN     in   1          sequence enable; level-sensitive
//  ACK    in   NGRP       per-group ready after release
//  Z      out  NGRP       1 = group released; 0 = tied (safe)
//  ZN     out  NGRP       bitwise ~Z, registered with Z (never skews)
//  STAGE  out  4          index of group being processed
//  DONE   out  1          all groups released and acked
//  FAULT  out  1          ACK timeout seen; sticky until EN low
// BEHAVIOUR
//  - One clock; reset synchronous, active-low: sampled only on CLK rise; RN=0 -> state IDLE,
//    Z=0, ZN=all 1, STAGE=0, DONE=0, FAULT=0, counters 0. RN dominates EN and ACK.
//  - All outputs registered; no combinational input->output path.
//  - States: IDLE, SETTLE, REL, DONE, FAULT.
//  - IDLE: EN=1 -> SETTLE, cnt=0, STAGE=0.
//  - SETTLE: cnt++ each cycle; at cnt==STAGE_CYC-1 -> REL, Z[STAGE]<=1 same edge, cnt=0.
//  - REL: ACK[STAGE]=1 -> if STAGE==NGRP-1 go DONE (DONE<=1), else STAGE++ and SETTLE.
//    ACK=0: cnt++; at cnt==TMO_CYC-1 with ACK still 0 -> FAULT, Z<=0 all groups, FAULT<=1.
//    ACK and timeout in same cycle: ACK wins.
//  - ACK only sampled for current STAGE; ACK of other groups ignored; ACK may drop after acked.
//  - Latency: first release = STAGE_CYC cycles after EN sampled high in IDLE; min total to DONE
//    = NGRP*(STAGE_CYC+1) cycles with ACK held high.
//  - DONE: hold Z=all 1, DONE=1 while EN=1.
//  - FAULT: Z=0, FAULT=1, STAGE frozen at failing group; exits only via EN=0.
//  - EN=0 in any state -> next edge: IDLE, Z=0, DONE=0, FAULT=0, STAGE=0 (abort mid-sequence is
//    an immediate full re-tie, not a reverse sequence).
//  - Reset mid-sequence: identical to EN=0 path plus counter clear.
//  - Counters sized $clog2(max(STAGE_CYC,TMO_CYC)+1); no wrap possible (bounded compares).
//  - STAGE upper bits 0 when NGRP<16.
// STRUCTURE
//  - Package gf180mcu_fd_sc_mcu7t5v0__tie_pkg: state enum (IDLE,SETTLE,REL,DONE,FAULT),
//    STAGE width constant, default STAGE_CYC/TMO_CYC localparams.
//  - One sub-module: gf180mcu_fd_sc_mcu7t5v0__tie_cnt (sync-clear down-counter with
//    terminal flag), instantiated once, shared by SETTLE and REL.
//  - Z/ZN from one register bank; ZN is ~ of next-Z, both flopped together.
// TESTING
//  - RN=0 3 cycles, EN=1, ACK=F -> Z=0,ZN=F,DONE=0,FAULT=0 throughout reset; RN=1 then Z[0]
//    rises exactly 8 cycles after EN sampled.
//  - NGRP=4, ACK=F held -> Z steps 1,3,7,F at 9-cycle spacing; DONE=1 with Z=F at cycle 36.
//  - ACK[1] never asserted -> 16 cycles after Z[1] rise: FAULT=1, Z=0, STAGE=1; persists until
//    EN=0, then FAULT=0, IDLE next edge.
//  - ACK[2] rises on cycle 16 of REL (timeout edge) -> no FAULT, STAGE advances to 3.
//  - EN drops while STAGE=2 in SETTLE -> next edge Z=0, STAGE=0; EN re-raised restarts at grp 0.
//  - ACK[3]=1 stuck while waiting grp 1 -> ignored; sequence waits/times out on ACK[1] only.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__tie_pkg.sv
// Shared types and constants for the staged tie-off release sequencer.
// Holds the state enum, STAGE width and default timing values.
package gf180mcu_fd_sc_mcu7t5v0__tie_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_REL,
        S_DONE,
        S_FAULT
    } state_e;

    localparam int STAGE_W       = 4;
    localparam int DEF_STAGE_CYC = 8;
    localparam int DEF_TMO_CYC   = 16;

    function automatic int cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__tie_release_seq_if.sv
// Enable/ack inputs and tie/status outputs of the release sequencer.
// The sequencer uses the slave view; the driver of EN/ACK uses master.
interface gf180mcu_fd_sc_mcu7t5v0__tie_release_seq_if
    import gf180mcu_fd_sc_mcu7t5v0__tie_pkg::*;
#(
    parameter int NGRP = 4
);

    logic               EN;
    logic [NGRP-1:0]    ACK;
    logic [NGRP-1:0]    Z;
    logic [NGRP-1:0]    ZN;
    logic [STAGE_W-1:0] STAGE;
    logic               DONE;
    logic               FAULT;

    modport master (
        output EN,
        output ACK,
        input  Z,
        input  ZN,
        input  STAGE,
        input  DONE,
        input  FAULT
    );

    modport slave (
        input  EN,
        input  ACK,
        output Z,
        output ZN,
        output STAGE,
        output DONE,
        output FAULT
    );

endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__tie_cnt.sv
// Sync-clear down-counter with terminal flag.
// Shared between settle timing and ack timeout.
module gf180mcu_fd_sc_mcu7t5v0__tie_cnt #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         term_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign term_o = (cnt_q == '0);

    // Saturates at zero so a stray decrement can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && !term_o) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__tie_release_seq.sv
// Staged tie-off release: groups leave their safe tie one at a time,
// each waiting for its ack; timeout or EN drop re-ties everything.
module gf180mcu_fd_sc_mcu7t5v0__tie_release_seq
    import gf180mcu_fd_sc_mcu7t5v0__tie_pkg::*;
#(
    parameter int NGRP      = 4,
    parameter int STAGE_CYC = DEF_STAGE_CYC,
    parameter int TMO_CYC   = DEF_TMO_CYC
) (
    input logic CLK,
    input logic RN,
    gf180mcu_fd_sc_mcu7t5v0__tie_release_seq_if.slave bus
);

    localparam int CNT_W = cnt_w(STAGE_CYC, TMO_CYC);
    localparam logic [CNT_W-1:0] SET_LD = CNT_W'(STAGE_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LD = CNT_W'(TMO_CYC - 1);
    localparam logic [STAGE_W-1:0] LAST = STAGE_W'(NGRP - 1);

    state_e state_q;
    state_e state_d;

    logic [NGRP-1:0]    z_q;
    logic [NGRP-1:0]    z_d;
    logic [NGRP-1:0]    zn_q;
    logic [STAGE_W-1:0] stage_q;
    logic [STAGE_W-1:0] stage_d;
    logic               done_q;
    logic               done_d;
    logic               fault_q;
    logic               fault_d;

    logic               cnt_clr;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_dec;
    logic               cnt_term;

    logic [NGRP-1:0]    sel;
    logic               ack_cur;
    logic               last;

    assign sel     = NGRP'(1) << stage_q;
    assign ack_cur = |(bus.ACK & sel);
    assign last    = (stage_q == LAST);

    gf180mcu_fd_sc_mcu7t5v0__tie_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk_i      (CLK),
        .rst_ni     (RN),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .term_o     (cnt_term)
    );

    always_comb begin
        state_d  = state_q;
        z_d      = z_q;
        stage_d  = stage_q;
        done_d   = done_q;
        fault_d  = fault_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = SET_LD;
        cnt_dec  = 1'b0;

        if (!bus.EN) begin
            // Abort is a full immediate re-tie, never a reverse walk.
            state_d = S_IDLE;
            z_d     = '0;
            stage_d = '0;
            done_d  = 1'b0;
            fault_d = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d  = S_SETTLE;
                    stage_d  = '0;
                    z_d      = '0;
                    cnt_load = 1'b1;
                    cnt_val  = SET_LD;
                end
                S_SETTLE: begin
                    if (cnt_term) begin
                        state_d  = S_REL;
                        z_d      = z_q | sel;
                        cnt_load = 1'b1;
                        cnt_val  = TMO_LD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                S_REL: begin
                    // Ack on the timeout edge still counts as success.
                    if (ack_cur) begin
                        if (last) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            cnt_clr = 1'b1;
                        end else begin
                            state_d  = S_SETTLE;
                            stage_d  = stage_q + STAGE_W'(1);
                            cnt_load = 1'b1;
                            cnt_val  = SET_LD;
                        end
                    end else if (cnt_term) begin
                        state_d = S_FAULT;
                        z_d     = '0;
                        fault_d = 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_IDLE;
                    z_d     = '0;
                    stage_d = '0;
                    done_d  = 1'b0;
                    fault_d = 1'b0;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // ZN comes from next-Z so both banks switch on the same edge.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q <= S_IDLE;
            z_q     <= '0;
            zn_q    <= '1;
            stage_q <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            zn_q    <= ~z_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign bus.Z     = z_q;
    assign bus.ZN    = zn_q;
    assign bus.STAGE = stage_q;
    assign bus.DONE  = done_q;
    assign bus.FAULT = fault_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__tie_release_seq.sv
// Bench for the tie release sequencer: planned ack timelines, random
// and directed, checked against a timeline model built from the rules.
module tb_gf180mcu_fd_sc_mcu7t5v0__tie_release_seq;

    localparam int NGRP = 4;
    localparam int SC   = 8;
    localparam int TMO  = 16;
    localparam int NEVER = 99;

    logic CLK;
    logic RN;

    int n_chk;
    int n_pass;
    int plan_k[NGRP];

    gf180mcu_fd_sc_mcu7t5v0__tie_release_seq_if #(.NGRP(NGRP)) bus ();

    gf180mcu_fd_sc_mcu7t5v0__tie_release_seq #(
        .NGRP      (NGRP),
        .STAGE_CYC (SC),
        .TMO_CYC   (TMO)
    ) dut (
        .CLK (CLK),
        .RN  (RN),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // plan_k[g]: edge (1..TMO) after release of g at which ACK[g] is
    // first seen high; anything else means it never comes.
    // noise: 0 random, 1 high, 2 low on ACK bits outside the ack windows.
    task automatic run_plan(input int ncyc, input int noise, input string tag);
        int r[NGRP];
        int ae[NGRP];
        bit acked[NGRP];
        int ng;
        int fault_e;
        int done_e;
        int t;
        bit stop;
        logic [NGRP-1:0] ack;
        logic [NGRP-1:0] ez;
        logic [3:0] est;
        logic ed;
        logic ef;

        ng = 0; fault_e = -1; done_e = -1; t = SC; stop = 0;
        for (int g = 0; g < NGRP; g++) begin
            r[g] = 0; ae[g] = 0; acked[g] = 0;
            if (!stop) begin
                r[g] = t;
                ng = g + 1;
                if (plan_k[g] >= 1 && plan_k[g] <= TMO) begin
                    acked[g] = 1;
                    ae[g] = t + plan_k[g];
                    if (g == NGRP - 1) done_e = ae[g];
                    t = ae[g] + SC;
                end else begin
                    fault_e = t + TMO;
                    stop = 1;
                end
            end
        end

        for (int e = 0; e < ncyc; e++) begin
            for (int j = 0; j < NGRP; j++) begin
                bit a;
                case (noise)
                    0:       a = 1'($urandom);
                    1:       a = 1'b1;
                    default: a = 1'b0;
                endcase
                if (j < ng && e > r[j]) begin
                    if (acked[j]) begin
                        if (e < ae[j]) a = 1'b0;
                        else if (e == ae[j]) a = 1'b1;
                    end else if (e <= fault_e) begin
                        a = 1'b0;
                    end
                end
                ack[j] = a;
            end
            bus.EN  = 1'b1;
            bus.ACK = ack;
            @(posedge CLK);
            @(negedge CLK);

            ez = '0;
            est = '0;
            for (int j = 0; j < ng; j++) begin
                if (e >= r[j]) ez[j] = 1'b1;
                if (acked[j] && e >= ae[j] && j < NGRP - 1) est = 4'(j + 1);
            end
            ef = (fault_e >= 0 && e >= fault_e);
            ed = (done_e >= 0 && e >= done_e);
            if (ef) ez = '0;

            n_chk++;
            if (bus.Z !== ez)
                $display("FAIL %s Z e=%0d got %h want %h", tag, e, bus.Z, ez);
            else n_pass++;
            n_chk++;
            if (bus.ZN !== ~ez)
                $display("FAIL %s ZN e=%0d got %h want %h", tag, e, bus.ZN, ~ez);
            else n_pass++;
            n_chk++;
            if (bus.STAGE !== est)
                $display("FAIL %s STAGE e=%0d got %0d want %0d", tag, e, bus.STAGE, est);
            else n_pass++;
            n_chk++;
            if (bus.DONE !== ed)
                $display("FAIL %s DONE e=%0d got %b want %b", tag, e, bus.DONE, ed);
            else n_pass++;
            n_chk++;
            if (bus.FAULT !== ef)
                $display("FAIL %s FAULT e=%0d got %b want %b", tag, e, bus.FAULT, ef);
            else n_pass++;
        end
    endtask

    task automatic go_idle(input string tag);
        bus.EN  = 1'b0;
        bus.ACK = 4'($urandom);
        @(posedge CLK);
        @(negedge CLK);
        n_chk++;
        if (bus.Z !== 4'h0 || bus.ZN !== 4'hF)
            $display("FAIL %s idle Z/ZN got %h/%h want 0/f", tag, bus.Z, bus.ZN);
        else n_pass++;
        n_chk++;
        if (bus.STAGE !== 4'd0)
            $display("FAIL %s idle STAGE got %0d want 0", tag, bus.STAGE);
        else n_pass++;
        n_chk++;
        if (bus.DONE !== 1'b0 || bus.FAULT !== 1'b0)
            $display("FAIL %s idle DONE/FAULT got %b/%b want 0/0", tag, bus.DONE, bus.FAULT);
        else n_pass++;
    endtask

    task automatic set_plan(input int k0, input int k1, input int k2, input int k3);
        plan_k[0] = k0; plan_k[1] = k1; plan_k[2] = k2; plan_k[3] = k3;
    endtask

    task automatic test_reset();
        RN = 1'b0;
        bus.EN = 1'b1;
        bus.ACK = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            n_chk++;
            if (bus.Z !== 4'h0 || bus.ZN !== 4'hF || bus.DONE !== 1'b0 ||
                bus.FAULT !== 1'b0 || bus.STAGE !== 4'd0)
                $display("FAIL reset cyc=%0d Z=%h ZN=%h D=%b F=%b S=%0d want 0 f 0 0 0",
                         i, bus.Z, bus.ZN, bus.DONE, bus.FAULT, bus.STAGE);
            else n_pass++;
        end
        RN = 1'b1;
        set_plan(1, 1, 1, 1);
        run_plan(12, 1, "reset_lat");
    endtask

    task automatic test_full_sequence();
        go_idle("full_pre");
        set_plan(1, 1, 1, 1);
        run_plan(40, 1, "full");
        n_chk++;
        if (bus.DONE !== 1'b1 || bus.Z !== 4'hF)
            $display("FAIL full_end DONE/Z got %b/%h want 1/f", bus.DONE, bus.Z);
        else n_pass++;
    endtask

    task automatic test_timeout();
        go_idle("tmo_pre");
        set_plan(1, NEVER, 1, 1);
        run_plan(50, 0, "tmo");
        n_chk++;
        if (bus.FAULT !== 1'b1 || bus.STAGE !== 4'd1 || bus.Z !== 4'h0)
            $display("FAIL tmo_hold F/S/Z got %b/%0d/%h want 1/1/0",
                     bus.FAULT, bus.STAGE, bus.Z);
        else n_pass++;
        go_idle("tmo_exit");
        set_plan(1, 1, 1, 1);
        run_plan(12, 1, "tmo_restart");
    endtask

    task automatic test_ack_at_timeout();
        go_idle("edge_pre");
        set_plan(1, 1, TMO, 1);
        run_plan(56, 2, "ack_edge");
    endtask

    task automatic test_en_drop();
        go_idle("drop_pre");
        set_plan(1, 1, 1, 1);
        run_plan(21, 1, "drop_run");
        go_idle("drop");
        run_plan(40, 1, "drop_restart");
    endtask

    task automatic test_other_ack_ignored();
        go_idle("other_pre");
        set_plan(1, NEVER, 1, 1);
        run_plan(40, 1, "other_ack");
    endtask

    task automatic test_reset_mid();
        go_idle("rstmid_pre");
        set_plan(1, 1, 1, 1);
        run_plan(30, 1, "rstmid_run");
        RN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        n_chk++;
        if (bus.Z !== 4'h0 || bus.ZN !== 4'hF || bus.STAGE !== 4'd0 || bus.DONE !== 1'b0)
            $display("FAIL rstmid Z/ZN/S/D got %h/%h/%0d/%b want 0/f/0/0",
                     bus.Z, bus.ZN, bus.STAGE, bus.DONE);
        else n_pass++;
        RN = 1'b1;
        run_plan(20, 0, "rstmid_restart");
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            go_idle("rnd_pre");
            for (int g = 0; g < NGRP; g++) begin
                int k;
                k = int'($urandom_range(1, TMO + 2));
                plan_k[g] = (k > TMO) ? NEVER : k;
            end
            run_plan(120, 0, "rnd");
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        RN = 1'b0;
        bus.EN = 1'b0;
        bus.ACK = '0;
        test_reset();
        test_full_sequence();
        test_timeout();
        test_ack_at_timeout();
        test_en_drop();
        test_other_ack_ignored();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
